tmds_ddr_serializer: RTL and testbench
======================================

TMDS_DDR_SERIALIZER -- requirements
Module: tmds_ddr_serializer

Interface
REQ-001 SHALL have parameter CLOCK_PATTERN, default 10'b0000011111, the 10-bit symbol sent on the TMDS clock lane for every pixel.
REQ-002 SHALL have port clk_shift, input, 1 bit: the single clock, at 5x pixel rate (DDR, 2 bits per lane per cycle).
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a symbol triple is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the holding buffer can accept a triple.
REQ-006 SHALL have ports in_red, in_green and in_blue, input, 10 bits each: TMDS-encoded symbols.
REQ-007 SHALL have ports out_clock, out_red, out_green and out_blue, output, 2 bits each: DDR pair per lane; [0] is transmitted first, [1] second.
REQ-008 SHALL have port underrun, output, 1 bit: one-cycle pulse when a load finds the buffer empty.

Function
REQ-009 SHALL keep a phase counter 0..4, incrementing every cycle and wrapping 4->0.
REQ-010 SHALL have one holding buffer (3x10 bits plus a full flag); in_ready SHALL equal NOT full, registered, with no combinational path from in_valid.
REQ-011 SHALL accept a triple on an edge where in_valid=1 and in_ready=1, writing the buffer and setting full.
REQ-012 The load edge SHALL be the edge where phase goes 4->0; on it each data lane shift register SHALL load its buffer symbol if full, and full SHALL clear.
REQ-013 Each output pair SHALL be the low 2 bits of its lane shift register; registers SHALL shift right by 2 on every non-load edge.
REQ-014 During phase k the outputs SHALL therefore carry symbol bits [2k+1:2k]: LSB first, 5 cycles per symbol.
REQ-015 The clock lane SHALL load CLOCK_PATTERN on every load edge, independent of buffer state.
REQ-016 Latency: a triple in the buffer before a load edge SHALL appear on the outputs on the cycle immediately after that edge.
REQ-017 Simultaneous accept and load with the buffer empty: the load SHALL be treated as an underrun, and the accepted triple SHALL be held for the next load.
REQ-018 With the buffer full on a load edge, in_ready SHALL be 0 on that edge; it returns to 1 on the following cycle.
REQ-019 underrun SHALL pulse for the cycle after a load edge with the buffer empty, but only once primed (at least one triple accepted since reset).
REQ-020 On an unprimed empty load, the lane behaviour of REQ-025/REQ-026 SHALL apply silently (no pulse).

Reset
REQ-021 While reset=1: phase=4, full=0, primed=0, in_ready=0, underrun=0.
REQ-022 Reset SHALL set the data lane shift registers to 10'b1101010100 and the clock lane to CLOCK_PATTERN.
REQ-023 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-024 Reset mid-symbol SHALL abandon the current symbol and the buffered triple.

Configuration
REQ-025 With TMDS_UNDERRUN_FILL_EN defined, an empty load SHALL load control symbol 10'b1101010100 into all three data lanes.
REQ-026 Without TMDS_UNDERRUN_FILL_EN, an empty load SHALL reload the last buffer contents (the buffer data is retained when full clears).

Structure
REQ-027 Package tmds_pkg SHALL hold: SYM_W=10, PAIRS=5, TMDS_CTRL_00=10'b1101010100, the default clock pattern, and the phase type (3 bits).
REQ-028 Sub-module tmds_shift_lane (10-bit load/shift-by-2 register with 2-bit output) SHALL be instantiated four times.
REQ-029 Outputs SHALL be register-driven so that they feed fake_differential directly.

Verification
REQ-030 Reset, then valid held with R=0x2AA, G=0x155, B=0x3FF -> red pairs 2,2,2,2,2; green 1,1,1,1,1; blue 3,3,3,3,3; clock 3,3,1... i.e. bits 1111100000 every symbol.
REQ-031 Stream triples every 5 cycles -> no underrun, in_ready low exactly on load edges, contiguous symbols.
REQ-032 Accept one triple, then stop -> one underrun pulse per subsequent load; lanes carry 0x354 (FILL_EN) or repeat the last symbol (no FILL_EN).
REQ-033 in_valid first asserted on the load edge after reset -> no underrun pulse; symbol sent at the following load.
REQ-034 Assert reset at phase 2 of a symbol -> outputs show the control symbol and clock pattern restarting; buffer empty; in_ready=0 during reset.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS DDR serializer.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;
  localparam int unsigned PAIRS = 5;

  localparam logic [SYM_W-1:0] TMDS_CTRL_00       = 10'b1101010100;
  localparam logic [SYM_W-1:0] TMDS_CLOCK_PATTERN = 10'b0000011111;

  typedef logic [2:0] phase_t;

  localparam phase_t PHASE_LOAD = phase_t'(PAIRS - 1);

endpackage

// File: rtl/tmds_shift_lane.sv
// One TMDS lane: 10-bit register that loads a symbol or shifts right by 2 each cycle.
module tmds_shift_lane
  import tmds_pkg::*;
#(
  parameter logic [SYM_W-1:0] RESET_SYM = TMDS_CTRL_00
) (
  input  logic             clk_shift,
  input  logic             reset,
  input  logic             load,
  input  logic [SYM_W-1:0] load_sym,
  output logic [1:0]       pair
);

  logic [SYM_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = {2'b00, sr_q[SYM_W-1:2]};
    if (load) begin
      sr_d = load_sym;
    end
  end

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      sr_q <= RESET_SYM;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Pair comes straight from flops so it can drive the output buffers directly.
  assign pair = sr_q[1:0];

endmodule

// File: rtl/tmds_ddr_serializer.sv
// TMDS 10:2 DDR serializer with a one-deep holding buffer for RGB symbol triples.
// Optional macro TMDS_UNDERRUN_FILL_EN: empty loads send the control symbol instead of a repeat.
module tmds_ddr_serializer
  import tmds_pkg::*;
#(
  parameter logic [SYM_W-1:0] CLOCK_PATTERN = TMDS_CLOCK_PATTERN
) (
  input  logic             clk_shift,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_red,
  input  logic [SYM_W-1:0] in_green,
  input  logic [SYM_W-1:0] in_blue,
  output logic [1:0]       out_clock,
  output logic [1:0]       out_red,
  output logic [1:0]       out_green,
  output logic [1:0]       out_blue,
  output logic             underrun
);

  phase_t           phase_q, phase_d;
  logic             full_q, full_d;
  logic             primed_q, primed_d;
  logic             ready_q;
  logic             underrun_q, underrun_d;
  logic [SYM_W-1:0] buf_r_q, buf_g_q, buf_b_q;
  logic [SYM_W-1:0] sym_r, sym_g, sym_b;
  logic             load, accept;

  assign load   = (phase_q == PHASE_LOAD);
  assign accept = in_valid & ready_q;

  always_comb begin
    phase_d    = load ? phase_t'(0) : phase_q + phase_t'(1);
    // A triple accepted on the load edge waits for the next one.
    full_d     = load ? accept : (full_q | accept);
    primed_d   = primed_q | accept;
    underrun_d = load & ~full_q & primed_q;
  end

  always_comb begin
    sym_r = buf_r_q;
    sym_g = buf_g_q;
    sym_b = buf_b_q;
`ifdef TMDS_UNDERRUN_FILL_EN
    if (!full_q) begin
      sym_r = TMDS_CTRL_00;
      sym_g = TMDS_CTRL_00;
      sym_b = TMDS_CTRL_00;
    end
`endif
  end

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      phase_q    <= PHASE_LOAD;
      full_q     <= 1'b0;
      primed_q   <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      buf_r_q    <= TMDS_CTRL_00;
      buf_g_q    <= TMDS_CTRL_00;
      buf_b_q    <= TMDS_CTRL_00;
    end else begin
      phase_q    <= phase_d;
      full_q     <= full_d;
      primed_q   <= primed_d;
      ready_q    <= ~full_d;
      underrun_q <= underrun_d;
      // Buffer data is kept after a load so an empty load can repeat it.
      if (accept) begin
        buf_r_q <= in_red;
        buf_g_q <= in_green;
        buf_b_q <= in_blue;
      end
    end
  end

  assign in_ready = ready_q;
  assign underrun = underrun_q;

  tmds_shift_lane #(.RESET_SYM(CLOCK_PATTERN)) u_lane_clock (
    .clk_shift(clk_shift),
    .reset    (reset),
    .load     (load),
    .load_sym (CLOCK_PATTERN),
    .pair     (out_clock)
  );

  tmds_shift_lane #(.RESET_SYM(TMDS_CTRL_00)) u_lane_red (
    .clk_shift(clk_shift),
    .reset    (reset),
    .load     (load),
    .load_sym (sym_r),
    .pair     (out_red)
  );

  tmds_shift_lane #(.RESET_SYM(TMDS_CTRL_00)) u_lane_green (
    .clk_shift(clk_shift),
    .reset    (reset),
    .load     (load),
    .load_sym (sym_g),
    .pair     (out_green)
  );

  tmds_shift_lane #(.RESET_SYM(TMDS_CTRL_00)) u_lane_blue (
    .clk_shift(clk_shift),
    .reset    (reset),
    .load     (load),
    .load_sym (sym_b),
    .pair     (out_blue)
  );

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// Self-checking bench for tmds_ddr_serializer against a symbol-level reference model.
module tb_tmds_ddr_serializer;
  import tmds_pkg::*;

`ifdef TMDS_UNDERRUN_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic       clk_shift = 1'b0;
  logic       reset     = 1'b1;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [9:0] in_red    = '0;
  logic [9:0] in_green  = '0;
  logic [9:0] in_blue   = '0;
  logic [1:0] out_clock, out_red, out_green, out_blue;
  logic       underrun;

  always #5 clk_shift = ~clk_shift;

  tmds_ddr_serializer dut (
    .clk_shift(clk_shift),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_red   (in_red),
    .in_green (in_green),
    .in_blue  (in_blue),
    .out_clock(out_clock),
    .out_red  (out_red),
    .out_green(out_green),
    .out_blue (out_blue),
    .underrun (underrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the symbol currently on each lane and the bit offset being sent.
  int         m_phase = 4;
  int         m_pos   = 0;
  bit         m_full, m_primed, m_ready, m_underrun, m_acc;
  logic [9:0] m_buf [3];
  logic [9:0] m_sym [4];
  int         n_underrun_obs = 0;
  int         n_underrun_exp = 0;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pair_of(input logic [9:0] s, input int pos);
    logic [9:0] t;
    t = s >> pos;
    return t[1:0];
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_phase = 4; m_pos = 0;
      m_full = 0; m_primed = 0; m_ready = 0; m_underrun = 0; m_acc = 0;
      m_sym[0] = TMDS_CLOCK_PATTERN;
      for (int i = 0; i < 3; i++) begin
        m_sym[i+1] = TMDS_CTRL_00;
        m_buf[i]   = TMDS_CTRL_00;
      end
    end else begin
      m_acc = in_valid && m_ready;
      if (m_phase == 4) begin
        m_underrun = !m_full && m_primed;
        m_sym[0]   = TMDS_CLOCK_PATTERN;
        for (int i = 0; i < 3; i++)
          m_sym[i+1] = (m_full || !FILL) ? m_buf[i] : TMDS_CTRL_00;
        m_pos  = 0;
        m_full = m_acc;
      end else begin
        m_underrun = 0;
        m_pos += 2;
        m_full = m_full || m_acc;
      end
      if (m_acc) begin
        m_buf[0] = in_red;
        m_buf[1] = in_green;
        m_buf[2] = in_blue;
      end
      m_primed = m_primed || m_acc;
      m_ready  = !m_full;
      m_phase  = (m_phase + 1) % 5;
    end
    if (m_underrun) n_underrun_exp++;
  endtask

  task automatic step();
    @(posedge clk_shift);
    model_edge();
    #1;
    if (underrun) n_underrun_obs++;
    check("in_ready",  10'(in_ready),  10'(m_ready));
    check("underrun",  10'(underrun),  10'(m_underrun));
    check("out_clock", 10'(out_clock), 10'(pair_of(m_sym[0], m_pos)));
    check("out_red",   10'(out_red),   10'(pair_of(m_sym[1], m_pos)));
    check("out_green", 10'(out_green), 10'(pair_of(m_sym[2], m_pos)));
    check("out_blue",  10'(out_blue),  10'(pair_of(m_sym[3], m_pos)));
  endtask

  task automatic rand_data();
    in_red   = 10'($urandom());
    in_green = 10'($urandom());
    in_blue  = 10'($urandom());
  endtask

  logic [1:0] clk_pairs [5];
  int         guard;

  initial begin
    clk_pairs = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd0};

    // Reset: ready low, no underrun, control symbol and clock pattern held.
    reset = 1'b1;
    repeat (3) step();
    check("rst_ready_low", 10'(in_ready), 10'd0);
    check("rst_red_ctrl",  10'(out_red),  10'd0);
    check("rst_clock",     10'(out_clock), 10'd3);

    // Valid first offered on the first load edge after reset, fixed pattern held.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_red   = 10'h2AA;
    in_green = 10'h155;
    in_blue  = 10'h3FF;
    step();
    check("ready_after_reset", 10'(in_ready), 10'd1);
    repeat (6) step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("fixed_red",   10'(out_red),   10'd2);
      check("fixed_green", 10'(out_green), 10'd1);
      check("fixed_blue",  10'(out_blue),  10'd3);
      check("fixed_clock", 10'(out_clock), 10'(clk_pairs[m_phase]));
    end
    check("no_underrun_first_load", 10'(n_underrun_obs), 10'd0);

    // Continuous streaming of fresh triples: never an underrun.
    for (int k = 0; k < 60; k++) begin
      step();
      if (m_acc) rand_data();
    end
    check("stream_no_underrun", 10'(n_underrun_obs), 10'd0);

    // Source stops: each later load edge reports an underrun.
    in_valid = 1'b0;
    repeat (26) step();
    check("stop_underrun_count", 10'(n_underrun_obs), 10'(n_underrun_exp));
    check("stop_underrun_nonzero", 10'(n_underrun_obs > 3), 10'd1);

    // Random traffic.
    for (int k = 0; k < 150; k++) begin
      in_valid = 1'($urandom());
      rand_data();
      step();
    end

    // Reset in the middle of a symbol.
    in_valid = 1'b1;
    rand_data();
    guard = 0;
    while (m_phase != 2 && guard < 6) begin
      step();
      guard++;
    end
    check("reach_phase2", 10'(m_phase), 10'd2);
    reset = 1'b1;
    repeat (2) step();
    check("midrst_ready_low", 10'(in_ready), 10'd0);
    check("midrst_clock",     10'(out_clock), 10'd3);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (12) step();
    check("midrst_underrun_total", 10'(n_underrun_obs), 10'(n_underrun_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
